// File: rtl/calc_pkg.sv
// Shared calculator definitions: operand widths, operator codes and ALU state encoding.
// The BCD state exists only when CALC_ALU_BCD_EN is defined.
package calc_pkg;

  localparam int W     = 8;
  localparam int RW    = 2 * W;
  localparam int CNT_W = 5;
  localparam int BCD_W = 20;

  localparam logic [7:0] OP_ADD  = 8'h80;
  localparam logic [7:0] OP_SUB  = 8'h81;
  localparam logic [7:0] OP_MUL  = 8'h82;
  localparam logic [7:0] OP_DIV  = 8'h83;
  localparam logic [7:0] OP_MOD  = 8'h84;
  localparam logic [7:0] OP_MOD3 = 8'h85;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    ITER = 3'd2,
`ifdef CALC_ALU_BCD_EN
    BCD  = 3'd3,
`endif
    DONE = 3'd4
  } alu_state_t;

  // Double-dabble pre-shift correction: every BCD digit >= 5 gets +3.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/calc_alu_seq_if.sv
// Request/result bundle between the stack controller and the sequential ALU.
// The bcd field is present only when CALC_ALU_BCD_EN is defined.
interface calc_alu_seq_if;
  import calc_pkg::*;

  logic             operand_valid;
  logic [W-1:0]     a;
  logic [7:0]       op;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [RW-1:0]    result;
  logic             neg;
  logic             err;
  logic             overrun;
`ifdef CALC_ALU_BCD_EN
  logic [BCD_W-1:0] bcd;

  modport master (
    output operand_valid, a, op, b,
    input  busy, done, result, neg, err, overrun, bcd
  );

  modport slave (
    input  operand_valid, a, op, b,
    output busy, done, result, neg, err, overrun, bcd
  );
`else
  modport master (
    output operand_valid, a, op, b,
    input  busy, done, result, neg, err, overrun
  );

  modport slave (
    input  operand_valid, a, op, b,
    output busy, done, result, neg, err, overrun
  );
`endif

endinterface

// File: rtl/calc_seq_divider.sv
// Restoring divider, one quotient bit per cycle for DW cycles after start.
// quotient/remainder present the value after the current cycle's step, so the last step is usable directly.
module calc_seq_divider
  import calc_pkg::*;
#(
  parameter int DW = W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          done
);

  localparam int CW = $clog2(DW);

  logic          active_r;
  logic [CW-1:0] cnt_r;
  logic [DW-1:0] quo_r;
  logic [DW-1:0] rem_r;
  logic [DW-1:0] dvs_r;
  logic [DW:0]   trial_s;
  logic          fits_s;

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  always_comb begin
    trial_s = {rem_r, quo_r[DW-1]};
    fits_s  = (trial_s >= {1'b0, dvs_r});
    if (fits_s) begin
      remainder = trial_s[DW-1:0] - dvs_r;
    end else begin
      remainder = trial_s[DW-1:0];
    end
    quotient = {quo_r[DW-2:0], fits_s};
  end

  assign done = active_r && (cnt_r == CW'(DW - 1));

  // Engine registers: load on start, then step until the last bit is produced.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      quo_r    <= {DW{1'b0}};
      rem_r    <= {DW{1'b0}};
      dvs_r    <= {DW{1'b0}};
    end else if (start) begin
      active_r <= 1'b1;
      cnt_r    <= {CW{1'b0}};
      quo_r    <= dividend;
      rem_r    <= {DW{1'b0}};
      dvs_r    <= divisor;
    end else if (active_r) begin
      quo_r <= quotient;
      rem_r <= remainder;
      if (done) begin
        active_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      active_r <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_alu_seq.sv
// Sequential calculator ALU: single-cycle add/sub, 8-cycle shift-add multiply and restoring divide.
// Define CALC_ALU_BCD_EN to add a 16-cycle double-dabble stage and the bcd output.
module calc_alu_seq
  import calc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  calc_alu_seq_if.slave bus
);

`ifdef CALC_ALU_BCD_EN
  localparam alu_state_t FIN_STATE = BCD;
`else
  localparam alu_state_t FIN_STATE = DONE;
`endif

  alu_state_t       state_r;
  alu_state_t       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [7:0]       op_r;

  logic [RW-1:0]    mul_acc_r;
  logic [RW-1:0]    mul_mcand_r;
  logic [W-1:0]     mul_mplier_r;
  logic [RW-1:0]    mul_acc_nxt_s;
  logic             mul_load_s;

  logic             div_start_s;
  logic             div_done_s;
  logic [W-1:0]     div_dvs_s;
  logic [W-1:0]     div_quo_s;
  logic [W-1:0]     div_rem_s;
  logic             iter_last_s;

  logic             accept_s;
  logic             fin_s;
  logic [RW-1:0]    fin_res_s;
  logic             fin_neg_s;
  logic             fin_err_s;
  logic             out_load_s;
  logic [RW-1:0]    out_res_s;
  logic             out_neg_s;
  logic             out_err_s;

  logic             busy_r;
  logic             done_r;
  logic [RW-1:0]    result_r;
  logic             neg_r;
  logic             err_r;
  logic             overrun_r;

  assign accept_s      = (state_r == IDLE) && bus.operand_valid;
  assign mul_acc_nxt_s = mul_acc_r + (mul_mplier_r[0] ? mul_mcand_r : {RW{1'b0}});
  assign div_dvs_s     = (op_r == OP_MOD3) ? W'(3) : b_r;
  assign iter_last_s   = (op_r == OP_MUL) ? (cnt_r == CNT_W'(W - 1)) : div_done_s;

  calc_seq_divider #(.DW(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_s),
    .dividend  (a_r),
    .divisor   (div_dvs_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s),
    .done      (div_done_s)
  );

  // Next-state and result-compute logic; fin_s marks the cycle the final value is known.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    fin_s       = 1'b0;
    fin_res_s   = {RW{1'b0}};
    fin_neg_s   = 1'b0;
    fin_err_s   = 1'b0;
    mul_load_s  = 1'b0;
    div_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.operand_valid) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        case (op_r)
          OP_ADD: begin
            fin_s       = 1'b1;
            fin_res_s   = RW'(a_r) + RW'(b_r);
            state_nxt_s = FIN_STATE;
          end
          OP_SUB: begin
            fin_s       = 1'b1;
            fin_res_s   = RW'(a_r) - RW'(b_r);
            fin_neg_s   = (a_r < b_r);
            state_nxt_s = FIN_STATE;
          end
          OP_MUL: begin
            mul_load_s  = 1'b1;
            state_nxt_s = ITER;
          end
          OP_DIV, OP_MOD: begin
            if (b_r == {W{1'b0}}) begin
              fin_s       = 1'b1;
              fin_res_s   = {RW{1'b1}};
              fin_err_s   = 1'b1;
              state_nxt_s = FIN_STATE;
            end else begin
              div_start_s = 1'b1;
              state_nxt_s = ITER;
            end
          end
          OP_MOD3: begin
            div_start_s = 1'b1;
            state_nxt_s = ITER;
          end
          default: begin
            fin_s       = 1'b1;
            fin_err_s   = 1'b1;
            state_nxt_s = FIN_STATE;
          end
        endcase
      end
      ITER: begin
        if (iter_last_s) begin
          fin_s       = 1'b1;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = FIN_STATE;
          case (op_r)
            OP_MUL:          fin_res_s = mul_acc_nxt_s;
            OP_DIV:          fin_res_s = {{(RW-W){1'b0}}, div_quo_s};
            OP_MOD, OP_MOD3: fin_res_s = {{(RW-W){1'b0}}, div_rem_s};
            default:         fin_res_s = {RW{1'b0}};
          endcase
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
`ifdef CALC_ALU_BCD_EN
      BCD: begin
        if (cnt_r == CNT_W'(RW - 1)) begin
          state_nxt_s = DONE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
`endif
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

`ifdef CALC_ALU_BCD_EN
  logic [RW-1:0]    hold_res_r;
  logic             hold_neg_r;
  logic             hold_err_r;
  logic [RW-1:0]    dd_bin_r;
  logic [BCD_W-1:0] dd_bcd_r;
  logic [BCD_W-1:0] dd_bcd_nxt_s;
  logic [BCD_W-1:0] dd_adj_s;
  logic [BCD_W-1:0] bcd_r;

  assign dd_adj_s     = bcd_adjust(dd_bcd_r);
  assign dd_bcd_nxt_s = {dd_adj_s[BCD_W-2:0], dd_bin_r[RW-1]};
  assign out_load_s   = (state_r == BCD) && (cnt_r == CNT_W'(RW - 1));
  assign out_res_s    = hold_res_r;
  assign out_neg_s    = hold_neg_r;
  assign out_err_s    = hold_err_r;
  assign bus.bcd      = bcd_r;

  // Result is parked while double-dabble converts it; bcd is published with result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_res_r <= {RW{1'b0}};
      hold_neg_r <= 1'b0;
      hold_err_r <= 1'b0;
      dd_bin_r   <= {RW{1'b0}};
      dd_bcd_r   <= {BCD_W{1'b0}};
      bcd_r      <= {BCD_W{1'b0}};
    end else begin
      if (fin_s) begin
        hold_res_r <= fin_res_s;
        hold_neg_r <= fin_neg_s;
        hold_err_r <= fin_err_s;
        dd_bin_r   <= fin_res_s;
        dd_bcd_r   <= {BCD_W{1'b0}};
      end else if (state_r == BCD) begin
        dd_bin_r <= {dd_bin_r[RW-2:0], 1'b0};
        dd_bcd_r <= dd_bcd_nxt_s;
      end else begin
        dd_bin_r <= dd_bin_r;
      end
      if (out_load_s) begin
        bcd_r <= dd_bcd_nxt_s;
      end else begin
        bcd_r <= bcd_r;
      end
    end
  end
`else
  assign out_load_s = fin_s;
  assign out_res_s  = fin_res_s;
  assign out_neg_s  = fin_neg_s;
  assign out_err_s  = fin_err_s;
`endif

  // FSM state and shared iteration counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Operands are captured only on an accepted request; dropped requests leave them intact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r  <= {W{1'b0}};
      b_r  <= {W{1'b0}};
      op_r <= 8'h00;
    end else if (accept_s) begin
      a_r  <= bus.a;
      b_r  <= bus.b;
      op_r <= bus.op;
    end else begin
      a_r <= a_r;
    end
  end

  // Shift-add multiplier: multiplicand shifts left, multiplier bits consumed LSB first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_acc_r    <= {RW{1'b0}};
      mul_mcand_r  <= {RW{1'b0}};
      mul_mplier_r <= {W{1'b0}};
    end else if (mul_load_s) begin
      mul_acc_r    <= {RW{1'b0}};
      mul_mcand_r  <= RW'(a_r);
      mul_mplier_r <= b_r;
    end else if (state_r == ITER) begin
      mul_acc_r    <= mul_acc_nxt_s;
      mul_mcand_r  <= {mul_mcand_r[RW-2:0], 1'b0};
      mul_mplier_r <= {1'b0, mul_mplier_r[W-1:1]};
    end else begin
      mul_acc_r <= mul_acc_r;
    end
  end

  // Registered outputs; busy falls on the same edge that raises done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= {RW{1'b0}};
      neg_r     <= 1'b0;
      err_r     <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      done_r <= out_load_s;
      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (out_load_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
      if (out_load_s) begin
        result_r <= out_res_s;
        neg_r    <= out_neg_s;
        err_r    <= out_err_s;
      end else begin
        result_r <= result_r;
      end
      if (bus.operand_valid && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.result  = result_r;
  assign bus.neg     = neg_r;
  assign bus.err     = err_r;
  assign bus.overrun = overrun_r;

endmodule

// File: doc/calc_alu_seq.md
Name: calc_alu_seq

Overview:
- Execution stage directly downstream of the calculator stack controller.
- Accepts one popped operand triple (a, op, b) per request and computes the result, using multi-cycle shift-add and restoring-divide engines.
- Presents a registered 16-bit result with status flags and a one-cycle done pulse to the display/result path.
- All arithmetic is unsigned 8-bit in, 16-bit out.

Parameters:
- W, 8, operand width; the iterative ops take W cycles.
- RW, 16, result width; fixed at 2*W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- operand_valid  in  1  one-cycle pulse: a/op/b are stable and form a new request
- a  in  W  first operand
- op  in  8  operator code (calc_pkg)
- b  in  W  second operand; ignored for OP_MOD3
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle pulse when result/flags update
- result  out  RW  registered result
- neg  out  1  SUB produced a negative value
- err  out  1  divide by zero or unknown op, for the last request
- overrun  out  1  sticky: a request arrived while busy; cleared only by reset
- bcd  out  20  5-digit BCD of result; present only with CALC_ALU_BCD_EN

Behaviour:
- Reset (rst=0, async): state IDLE; busy, done, neg, err and overrun = 0; result = 0; bcd = 0; iteration counter = 0.
- Op codes:
  - 8'h80 ADD; 8'h81 SUB; 8'h82 MUL; 8'h83 DIV; 8'h84 MOD.
  - 8'h85 MOD3 computes a mod 3; the upstream controller forces b=0 for this op.
  - Any other code is unknown.
- FSM states: IDLE, EXEC, ITER, (BCD), DONE.
- IDLE:
  - On operand_valid: latch a, op, b; go to EXEC; busy=1 from the next cycle.
- EXEC, ADD: result = zero-extended a+b (max 510); go to DONE.
- EXEC, SUB: result = a-b as 16-bit two's complement (5-9 gives 16'hFFFC); neg = (a<b); go to DONE.
- EXEC, unknown op: result = 0, err = 1; go to DONE.
- EXEC, DIV/MOD with b=0: result = 16'hFFFF, err = 1; go to DONE without iterating.
- EXEC, MUL/DIV/MOD/MOD3 otherwise: load the engine and clear the counter; go to ITER.
- ITER:
  - Runs exactly W cycles, counter 0..W-1; the W-th cycle goes to DONE.
  - MUL: shift-add, 16-bit product.
  - DIV/MOD/MOD3: restoring divide, one quotient bit per cycle.
  - MOD3 uses divisor 3.
  - DIV returns the quotient, zero-extended; MOD/MOD3 return the remainder, zero-extended.
- DONE:
  - result, neg and err are written together; done=1 for exactly this cycle.
  - neg and err are cleared for any op that does not set them.
  - Next state is IDLE; busy drops in the same cycle done rises.
- Latency from the operand_valid edge to the done-high cycle:
  - ADD, SUB, unknown op, divide-by-zero: 2 cycles.
  - MUL, DIV, MOD, MOD3: 2+W cycles (10 at W=8).
- operand_valid while busy: request dropped, latched operands unchanged, overrun set.
- operand_valid in the DONE cycle counts as busy and is dropped.
- operand_valid in the cycle after done is accepted.
- result holds its value between requests; it changes only in DONE or on reset.
- Reset mid-operation: immediate return to the reset values; the partial result is discarded and no done pulse is issued.

Optional Feature:
- Macro: CALC_ALU_BCD_EN.
- Defined:
  - A BCD state is inserted between the result compute and DONE.
  - It runs 16-cycle sequential double-dabble on the 16-bit result.
  - The bcd port exists; bcd and result update in the same DONE cycle.
  - Every latency above grows by 16 cycles.
  - A negative SUB result converts the 16-bit magnitude; neg still marks the sign.
  - An err result converts 0 or 65535 as produced.
- Undefined: no bcd port, no BCD state, latencies as listed.

Decomposition:
- calc_pkg:
  - op code localparams OP_ADD..OP_MOD3;
  - state enum typedef alu_state_t;
  - W/RW defaults.
  - Shared with the stack controller so op codes have a single definition.
- One sub-module: calc_seq_divider (restoring divider, start/done, quotient/remainder). The multiplier stays inline.

Test Plan:
- Add: a=200, op=80, b=100 -> done 2 cycles later, result=16'h012C, neg=0, err=0.
- Subtract: a=5, op=81, b=9 -> result=16'hFFFC, neg=1. Then a=9, b=5 -> result=4, neg=0.
- Multiply: a=255, op=82, b=255 -> busy for 10 cycles, done at cycle 10, result=16'hFE01.
- Divide and modulo:
  - 200/7 (op=83) -> result 28.
  - 200 mod 7 (op=84) -> result 4.
  - a=100, op=85 -> result 1.
  - a=9, op=83, b=0 -> result 16'hFFFF, err=1, done at cycle 2.
- Overrun and reset:
  - Second operand_valid during MUL -> ignored, overrun=1, first result still correct.
  - Unknown op 8'h7F -> err=1, result=0.
  - rst low mid-ITER -> all outputs 0 and no done pulse.
- With CALC_ALU_BCD_EN: a=255 * b=255 -> bcd=20'h65025, done at cycle 26. ADD 200+100 -> bcd=20'h00300.
